// File: rtl/csr_exc_unit_pkg.sv
// Shared CSR address map, exception codes and field positions for csr_exc_unit.
package csr_exc_unit_pkg;

  typedef enum logic [13:0] {
    CSR_CRMD      = 14'h000,
    CSR_PRMD      = 14'h001,
    CSR_ECFG      = 14'h004,
    CSR_ESTAT     = 14'h005,
    CSR_ERA       = 14'h006,
    CSR_BADV      = 14'h007,
    CSR_EENTRY    = 14'h00c,
    CSR_SAVE0     = 14'h030,
    CSR_SAVE1     = 14'h031,
    CSR_SAVE2     = 14'h032,
    CSR_SAVE3     = 14'h033,
    CSR_TID       = 14'h040,
    CSR_TCFG      = 14'h041,
    CSR_TVAL      = 14'h042,
    CSR_TICLR     = 14'h044,
    CSR_TLBRENTRY = 14'h088
  } csr_addr_e;

  typedef enum logic [5:0] {
    ECODE_INT  = 6'h00,
    ECODE_PIL  = 6'h01,
    ECODE_PIS  = 6'h02,
    ECODE_PIF  = 6'h03,
    ECODE_PME  = 6'h04,
    ECODE_PPI  = 6'h07,
    ECODE_ADE  = 6'h08,
    ECODE_ALE  = 6'h09,
    ECODE_SYS  = 6'h0b,
    ECODE_BRK  = 6'h0c,
    ECODE_INE  = 6'h0d,
    ECODE_TLBR = 6'h3f
  } ecode_e;

  localparam int CRMD_IE = 2;
  localparam int CRMD_DA = 3;
  localparam int CRMD_PG = 4;

  localparam int TCFG_EN       = 0;
  localparam int TCFG_PERIODIC = 1;

  localparam logic [31:0] CRMD_WMASK  = 32'h0000_01ff;
  localparam logic [31:0] PRMD_WMASK  = 32'h0000_0007;
  localparam logic [31:0] ECFG_WMASK  = 32'h0000_1bff;
  localparam logic [31:0] ENTRY_WMASK = 32'hffff_ffc0;
  localparam logic [31:0] FULL_WMASK  = 32'hffff_ffff;

  function automatic logic [31:0] csr_merge(input logic [31:0] old, input logic [31:0] wvalue,
                                            input logic [31:0] wmask, input logic [31:0] writable);
    logic [31:0] m;
    m = wmask & writable;
    return (old & ~m) | (wvalue & m);
  endfunction

endpackage

// File: rtl/csr_timer.sv
// Timer CSRs (TCFG/TVAL/TICLR): countdown, reload and the ESTAT.IS[11] timer interrupt bit.
module csr_timer
  import csr_exc_unit_pkg::*;
#(
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               csr_wr,
  input  logic [13:0]        csr_num,
  input  logic [31:0]        csr_wmask,
  input  logic [31:0]        csr_wvalue,
  output logic [TIMER_W-1:0] tcfg,
  output logic [TIMER_W-1:0] tval,
  output logic               timer_int
);

  logic [TIMER_W-1:0] tcfg_next;
  logic [TIMER_W-1:0] reload;
  logic               tcfg_wr;
  logic               ticlr_wr;
  logic               armed;
  logic               fire;

  assign tcfg_wr   = csr_wr && (csr_num == CSR_TCFG);
  assign ticlr_wr  = csr_wr && (csr_num == CSR_TICLR) && csr_wvalue[0] && csr_wmask[0];
  assign tcfg_next = (tcfg & ~csr_wmask[TIMER_W-1:0]) | (csr_wvalue[TIMER_W-1:0] & csr_wmask[TIMER_W-1:0]);
  assign reload    = {tcfg[TIMER_W-1:2], 2'b00};

  // A one-shot timer disarms after its fire so the wrap to all-ones never fires again.
  assign fire = tcfg[TCFG_EN] && armed && (tval == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      tcfg      <= '0;
      tval      <= '1;
      armed     <= 1'b0;
      timer_int <= 1'b0;
    end else begin
      if (tcfg_wr) begin
        tcfg  <= tcfg_next;
        tval  <= {tcfg_next[TIMER_W-1:2], 2'b00};
        armed <= tcfg_next[TCFG_EN];
      end else if (tcfg[TCFG_EN]) begin
        if (tval == '0) begin
          tval <= tcfg[TCFG_PERIODIC] ? reload : '1;
          if (!tcfg[TCFG_PERIODIC]) begin
            armed <= 1'b0;
          end
        end else begin
          tval <= tval - TIMER_W'(1);
        end
      end

      // A fire landing in the same cycle as a TICLR clear keeps the interrupt set.
      if (fire) begin
        timer_int <= 1'b1;
      end else if (ticlr_wr) begin
        timer_int <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/csr_exc_unit.sv
// Privileged CSR file with exception entry / ERTN return between writeback and fetch.
// Optional timer (TCFG/TVAL/TICLR, ESTAT.IS[11]) is built only when CSR_TIMER_EN is defined.
module csr_exc_unit
  import csr_exc_unit_pkg::*;
#(
  parameter int TIMER_W = 32,
  parameter int HWI_N   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             csr_re,
  input  logic [13:0]      csr_num,
  output logic [31:0]      csr_rvalue,
  input  logic             csr_we,
  input  logic [31:0]      csr_wmask,
  input  logic [31:0]      csr_wvalue,
  input  logic             ertn_flush,
  input  logic             wb_ex,
  input  logic [5:0]       wb_ecode,
  input  logic [8:0]       wb_esubcode,
  input  logic [31:0]      wb_pc,
  input  logic [31:0]      wb_vaddr,
  input  logic [HWI_N-1:0] hw_int_in,
  input  logic             ipi_int_in,
  output logic             has_int,
  output logic [31:0]      ex_entry,
  output logic [31:0]      ertn_pc
);

  logic [31:0]      crmd;
  logic [31:0]      prmd;
  logic [31:0]      ecfg;
  logic [1:0]       is_sw;
  logic [HWI_N-1:0] hwi;
  logic             ipi;
  logic [5:0]       ecode;
  logic [8:0]       esubcode;
  logic [31:0]      era;
  logic [31:0]      badv;
  logic [31:0]      eentry;
  logic [31:0]      save [4];
  logic [31:0]      tid;
  logic [31:0]      tlbrentry;

  logic [12:0]        estat_is;
  logic [31:0]        estat;
  logic [31:0]        rdata;
  logic               csr_wr;
  logic               badv_hit;
  logic [TIMER_W-1:0] tcfg_bits;
  logic [TIMER_W-1:0] tval_bits;
  logic               timer_int;

  // Exceptions and ERTN both pre-empt a CSR write retiring in the same cycle.
  assign csr_wr = csr_we && !wb_ex && !ertn_flush;

`ifdef CSR_TIMER_EN
  csr_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .csr_wr     (csr_wr),
    .csr_num    (csr_num),
    .csr_wmask  (csr_wmask),
    .csr_wvalue (csr_wvalue),
    .tcfg       (tcfg_bits),
    .tval       (tval_bits),
    .timer_int  (timer_int)
  );
`else
  assign tcfg_bits = '0;
  assign tval_bits = '0;
  assign timer_int = 1'b0;
`endif

  assign estat_is = {ipi, timer_int, 1'b0, 8'(hwi), is_sw};
  assign estat    = {1'b0, esubcode, ecode, 3'b000, estat_is};
  assign badv_hit = wb_ecode inside {ECODE_PIL, ECODE_PIS, ECODE_PIF, ECODE_PME,
                                     ECODE_PPI, ECODE_ADE, ECODE_ALE, ECODE_TLBR};

  always_ff @(posedge clk) begin
    if (reset) begin
      crmd      <= 32'h0000_0008;
      prmd      <= '0;
      ecfg      <= '0;
      is_sw     <= '0;
      hwi       <= '0;
      ipi       <= 1'b0;
      ecode     <= '0;
      esubcode  <= '0;
      era       <= '0;
      badv      <= '0;
      eentry    <= '0;
      tid       <= '0;
      tlbrentry <= '0;
      for (int i = 0; i < 4; i++) begin
        save[i] <= '0;
      end
    end else begin
      hwi <= hw_int_in;
      ipi <= ipi_int_in;

      if (wb_ex) begin
        prmd[2:0] <= crmd[2:0];
        crmd[2:0] <= 3'b000;
        era       <= wb_pc;
        ecode     <= wb_ecode;
        esubcode  <= wb_esubcode;
        if (wb_ecode == ECODE_TLBR) begin
          crmd[CRMD_DA] <= 1'b1;
          crmd[CRMD_PG] <= 1'b0;
        end
        // ADEF reports the fetch PC; every other address fault reports the data/fetch vaddr.
        if (badv_hit) begin
          badv <= (wb_ecode == ECODE_ADE && wb_esubcode == 9'd0) ? wb_pc : wb_vaddr;
        end
      end else if (ertn_flush) begin
        crmd[2:0] <= prmd[2:0];
        if (ecode == ECODE_TLBR) begin
          crmd[CRMD_DA] <= 1'b0;
          crmd[CRMD_PG] <= 1'b1;
        end
      end else if (csr_wr) begin
        case (csr_num)
          CSR_CRMD:      crmd      <= csr_merge(crmd, csr_wvalue, csr_wmask, CRMD_WMASK);
          CSR_PRMD:      prmd      <= csr_merge(prmd, csr_wvalue, csr_wmask, PRMD_WMASK);
          CSR_ECFG:      ecfg      <= csr_merge(ecfg, csr_wvalue, csr_wmask, ECFG_WMASK);
          CSR_ESTAT:     is_sw     <= (is_sw & ~csr_wmask[1:0]) | (csr_wvalue[1:0] & csr_wmask[1:0]);
          CSR_ERA:       era       <= csr_merge(era, csr_wvalue, csr_wmask, FULL_WMASK);
          CSR_BADV:      badv      <= csr_merge(badv, csr_wvalue, csr_wmask, FULL_WMASK);
          CSR_EENTRY:    eentry    <= csr_merge(eentry, csr_wvalue, csr_wmask, ENTRY_WMASK);
          CSR_SAVE0:     save[0]   <= csr_merge(save[0], csr_wvalue, csr_wmask, FULL_WMASK);
          CSR_SAVE1:     save[1]   <= csr_merge(save[1], csr_wvalue, csr_wmask, FULL_WMASK);
          CSR_SAVE2:     save[2]   <= csr_merge(save[2], csr_wvalue, csr_wmask, FULL_WMASK);
          CSR_SAVE3:     save[3]   <= csr_merge(save[3], csr_wvalue, csr_wmask, FULL_WMASK);
          CSR_TID:       tid       <= csr_merge(tid, csr_wvalue, csr_wmask, FULL_WMASK);
          CSR_TLBRENTRY: tlbrentry <= csr_merge(tlbrentry, csr_wvalue, csr_wmask, ENTRY_WMASK);
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (csr_num)
      CSR_CRMD:      rdata = crmd;
      CSR_PRMD:      rdata = prmd;
      CSR_ECFG:      rdata = ecfg;
      CSR_ESTAT:     rdata = estat;
      CSR_ERA:       rdata = era;
      CSR_BADV:      rdata = badv;
      CSR_EENTRY:    rdata = eentry;
      CSR_SAVE0:     rdata = save[0];
      CSR_SAVE1:     rdata = save[1];
      CSR_SAVE2:     rdata = save[2];
      CSR_SAVE3:     rdata = save[3];
      CSR_TID:       rdata = tid;
      CSR_TCFG:      rdata = 32'(tcfg_bits);
      CSR_TVAL:      rdata = 32'(tval_bits);
      CSR_TLBRENTRY: rdata = tlbrentry;
      default:       rdata = '0;
    endcase
  end

  assign csr_rvalue = csr_re ? rdata : '0;
  assign has_int    = crmd[CRMD_IE] && |(estat_is & ecfg[12:0]);
  assign ex_entry   = (wb_ecode == ECODE_TLBR) ? tlbrentry : eentry;
  assign ertn_pc    = era;

endmodule

// File: tb/tb_csr_exc_unit.sv
// Table-driven bench for csr_exc_unit; timer checks follow the CSR_TIMER_EN build option.
module tb_csr_exc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        ertn_flush;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic        has_int;
  logic [31:0] ex_entry;
  logic [31:0] ertn_pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  csr_exc_unit dut (
    .clk         (clk),
    .reset       (reset),
    .csr_re      (csr_re),
    .csr_num     (csr_num),
    .csr_rvalue  (csr_rvalue),
    .csr_we      (csr_we),
    .csr_wmask   (csr_wmask),
    .csr_wvalue  (csr_wvalue),
    .ertn_flush  (ertn_flush),
    .wb_ex       (wb_ex),
    .wb_ecode    (wb_ecode),
    .wb_esubcode (wb_esubcode),
    .wb_pc       (wb_pc),
    .wb_vaddr    (wb_vaddr),
    .hw_int_in   (hw_int_in),
    .ipi_int_in  (ipi_int_in),
    .has_int     (has_int),
    .ex_entry    (ex_entry),
    .ertn_pc     (ertn_pc)
  );

  typedef struct {
    bit          we;
    bit          ex;
    bit          ertn;
    logic [13:0] num;
    logic [31:0] wm;
    logic [31:0] wv;
    logic [5:0]  ec;
    logic [8:0]  es;
    logic [31:0] pc;
    logic [31:0] va;
    logic [7:0]  hw;
    bit          ipi;
    logic [13:0] rd;
    logic [31:0] exp_rv;
    bit          exp_hi;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit we, bit ex, bit ertn, logic [13:0] num, logic [31:0] wm,
                              logic [31:0] wv, logic [5:0] ec, logic [8:0] es, logic [31:0] pc,
                              logic [31:0] va, logic [7:0] hw, bit ipi, logic [13:0] rd,
                              logic [31:0] exp_rv, bit exp_hi);
    vec_t v;
    v.we = we; v.ex = ex; v.ertn = ertn; v.num = num; v.wm = wm; v.wv = wv;
    v.ec = ec; v.es = es; v.pc = pc; v.va = va; v.hw = hw; v.ipi = ipi;
    v.rd = rd; v.exp_rv = exp_rv; v.exp_hi = exp_hi;
    return v;
  endfunction

  function automatic vec_t v_wr(logic [13:0] num, logic [31:0] wm, logic [31:0] wv,
                                logic [13:0] rd, logic [31:0] exp_rv, bit exp_hi);
    return mk(1, 0, 0, num, wm, wv, 0, 0, 0, 0, 0, 0, rd, exp_rv, exp_hi);
  endfunction

  function automatic vec_t v_ex(logic [5:0] ec, logic [8:0] es, logic [31:0] pc, logic [31:0] va,
                                logic [13:0] rd, logic [31:0] exp_rv, bit exp_hi);
    return mk(0, 1, 0, 0, 0, 0, ec, es, pc, va, 0, 0, rd, exp_rv, exp_hi);
  endfunction

  function automatic vec_t v_idle(logic [13:0] rd, logic [31:0] exp_rv, bit exp_hi);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rd, exp_rv, exp_hi);
  endfunction

  function automatic vec_t v_ertn(logic [13:0] rd, logic [31:0] exp_rv, bit exp_hi);
    return mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, rd, exp_rv, exp_hi);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic drive_idle(input logic [13:0] rd);
    csr_re     = 1'b1;
    csr_num    = rd;
    csr_we     = 1'b0;
    csr_wmask  = '0;
    csr_wvalue = '0;
    wb_ex      = 1'b0;
    ertn_flush = 1'b0;
    wb_ecode   = '0;
    wb_esubcode = '0;
    wb_pc      = '0;
    wb_vaddr   = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic readCheck(input string name, input logic [13:0] num, input logic [31:0] expected);
    csr_re  = 1'b1;
    csr_num = num;
    #1;
    checkOutput(name, csr_rvalue, expected);
  endtask

  task automatic writeCsr(input logic [13:0] num, input logic [31:0] wm, input logic [31:0] wv);
    @(negedge clk);
    csr_re     = 1'b0;
    csr_we     = 1'b1;
    csr_num    = num;
    csr_wmask  = wm;
    csr_wvalue = wv;
    tick();
    drive_idle(num);
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    @(negedge clk);
    csr_re      = 1'b0;
    csr_we      = v.we;
    wb_ex       = v.ex;
    ertn_flush  = v.ertn;
    csr_num     = v.num;
    csr_wmask   = v.wm;
    csr_wvalue  = v.wv;
    wb_ecode    = v.ec;
    wb_esubcode = v.es;
    wb_pc       = v.pc;
    wb_vaddr    = v.va;
    hw_int_in   = v.hw;
    ipi_int_in  = v.ipi;
    tick();
    drive_idle(v.rd);
    #1;
    checkOutput($sformatf("vec%0d rvalue", idx), csr_rvalue, v.exp_rv);
    checkOutput($sformatf("vec%0d has_int", idx), {31'b0, has_int}, {31'b0, v.exp_hi});
  endtask

  initial begin
    reset      = 1'b1;
    hw_int_in  = '0;
    ipi_int_in = 1'b0;
    drive_idle(14'h0);

    // Directed vectors; CSR state is carried from one row to the next.
    vecs.push_back(v_wr(14'h030, 32'hffff_0000, 32'hdead_beef, 14'h030, 32'hdead_0000, 0));
    vecs.push_back(v_wr(14'h000, 32'h0000_0007, 32'h0000_0007, 14'h000, 32'h0000_000f, 0));
    vecs.push_back(v_ex(6'h0b, 9'd0, 32'h1c00_0100, 32'h0, 14'h001, 32'h0000_0007, 0));
    vecs.push_back(v_idle(14'h000, 32'h0000_0008, 0));
    vecs.push_back(v_idle(14'h006, 32'h1c00_0100, 0));
    vecs.push_back(v_idle(14'h005, 32'h000b_0000, 0));
    vecs.push_back(v_idle(14'h007, 32'h0000_0000, 0));
    vecs.push_back(v_ertn(14'h000, 32'h0000_000f, 0));
    vecs.push_back(v_ex(6'h08, 9'd0, 32'h1c00_0003, 32'h1234_5678, 14'h007, 32'h1c00_0003, 0));
    vecs.push_back(v_ex(6'h08, 9'd1, 32'h1c00_0004, 32'h0000_0abc, 14'h007, 32'h0000_0abc, 0));
    vecs.push_back(v_ex(6'h09, 9'd0, 32'h1c00_0005, 32'h0000_1234, 14'h007, 32'h0000_1234, 0));
    vecs.push_back(v_ex(6'h0d, 9'd0, 32'h1c00_0008, 32'hffff_0000, 14'h007, 32'h0000_1234, 0));
    vecs.push_back(v_wr(14'h088, 32'hffff_ffff, 32'hffff_ffff, 14'h088, 32'hffff_ffc0, 0));
    vecs.push_back(v_wr(14'h00c, 32'hffff_ffff, 32'h1c00_8000, 14'h00c, 32'h1c00_8000, 0));
    vecs.push_back(v_wr(14'h000, 32'hffff_ffff, 32'hffff_ffff, 14'h000, 32'h0000_01ff, 0));
    vecs.push_back(v_wr(14'h000, 32'hffff_ffff, 32'h0000_0010, 14'h000, 32'h0000_0010, 0));
    vecs.push_back(v_ex(6'h3f, 9'd0, 32'h1c00_0010, 32'h8000_0000, 14'h007, 32'h8000_0000, 0));
    vecs.push_back(v_idle(14'h000, 32'h0000_0008, 0));
    vecs.push_back(v_ertn(14'h000, 32'h0000_0010, 0));
    vecs.push_back(v_wr(14'h005, 32'hffff_ffff, 32'hffff_ffff, 14'h005, 32'h003f_0003, 0));
    vecs.push_back(v_wr(14'h004, 32'hffff_ffff, 32'h0000_0001, 14'h004, 32'h0000_0001, 0));
    vecs.push_back(v_wr(14'h000, 32'h0000_0004, 32'h0000_0004, 14'h000, 32'h0000_0014, 1));
    vecs.push_back(v_wr(14'h005, 32'h0000_0003, 32'h0000_0000, 14'h005, 32'h003f_0000, 0));
    vecs.push_back(mk(1, 1, 0, 14'h031, 32'hffff_ffff, 32'h1111_1111, 6'h0b, 9'd0, 32'h1c00_0020,
                      32'h0, 8'h00, 0, 14'h031, 32'h0, 0));
    vecs.push_back(mk(1, 0, 1, 14'h032, 32'hffff_ffff, 32'h2222_2222, 6'h00, 9'd0, 32'h0,
                      32'h0, 8'h00, 0, 14'h032, 32'h0, 0));
    vecs.push_back(v_idle(14'h000, 32'h0000_0014, 0));
    vecs.push_back(mk(1, 0, 0, 14'h004, 32'hffff_ffff, 32'h0000_0004, 6'h00, 9'd0, 32'h0,
                      32'h0, 8'h01, 0, 14'h005, 32'h000b_0004, 1));
    vecs.push_back(v_idle(14'h005, 32'h000b_0000, 0));
    vecs.push_back(mk(1, 0, 0, 14'h004, 32'hffff_ffff, 32'h0000_1000, 6'h00, 9'd0, 32'h0,
                      32'h0, 8'h00, 1, 14'h005, 32'h000b_1000, 1));
    vecs.push_back(v_idle(14'h005, 32'h000b_0000, 0));
    vecs.push_back(v_wr(14'h040, 32'hffff_ffff, 32'hcafe_f00d, 14'h040, 32'hcafe_f00d, 0));
    vecs.push_back(v_wr(14'h999, 32'hffff_ffff, 32'hffff_ffff, 14'h999, 32'h0000_0000, 0));
    vecs.push_back(v_wr(14'h033, 32'h0000_ffff, 32'h1234_5678, 14'h033, 32'h0000_5678, 0));
    vecs.push_back(v_wr(14'h001, 32'hffff_ffff, 32'hffff_ffff, 14'h001, 32'h0000_0007, 0));

    repeat (2) tick();
    reset = 1'b0;
    readCheck("rst crmd", 14'h000, 32'h0000_0008);
    readCheck("rst estat", 14'h005, 32'h0);
    readCheck("rst era", 14'h006, 32'h0);
    readCheck("rst unimpl", 14'h999, 32'h0);
    checkOutput("rst has_int", {31'b0, has_int}, 32'h0);
    checkOutput("rst ertn_pc", ertn_pc, 32'h0);
    checkOutput("rst ex_entry", ex_entry, 32'h0);
`ifdef CSR_TIMER_EN
    readCheck("rst tval", 14'h042, 32'hffff_ffff);
`else
    readCheck("rst tval", 14'h042, 32'h0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(i, vecs[i]);
    end

    checkOutput("ertn_pc era", ertn_pc, 32'h1c00_0020);
    wb_ecode = 6'h3f;
    #1;
    checkOutput("ex_entry tlbr", ex_entry, 32'hffff_ffc0);
    wb_ecode = 6'h0b;
    #1;
    checkOutput("ex_entry eentry", ex_entry, 32'h1c00_8000);
    wb_ecode = 6'h00;

    // Timer: InitVal 1 gives TVAL 4, so each period spans five edges.
    writeCsr(14'h004, 32'hffff_ffff, 32'h0000_0800);
`ifdef CSR_TIMER_EN
    writeCsr(14'h041, 32'hffff_ffff, 32'h0000_0007);
    readCheck("tval load", 14'h042, 32'h4);
    repeat (4) tick();
    readCheck("tval zero", 14'h042, 32'h0);
    checkOutput("pre-fire has_int", {31'b0, has_int}, 32'h0);
    tick();
    checkOutput("fire has_int", {31'b0, has_int}, 32'h1);
    readCheck("fire estat", 14'h005, 32'h000b_0800);
    readCheck("tval reload", 14'h042, 32'h4);
    writeCsr(14'h044, 32'h1, 32'h1);
    checkOutput("ticlr has_int", {31'b0, has_int}, 32'h0);
    repeat (3) tick();
    checkOutput("gap has_int", {31'b0, has_int}, 32'h0);
    tick();
    checkOutput("refire has_int", {31'b0, has_int}, 32'h1);
    writeCsr(14'h044, 32'h1, 32'h1);
    repeat (3) tick();
    writeCsr(14'h044, 32'h1, 32'h1);
    checkOutput("fire beats clr", {31'b0, has_int}, 32'h1);
    writeCsr(14'h044, 32'h1, 32'h1);
    checkOutput("clr again", {31'b0, has_int}, 32'h0);
    writeCsr(14'h041, 32'hffff_ffff, 32'h0000_0005);
    readCheck("tcfg oneshot", 14'h041, 32'h5);
    repeat (5) tick();
    checkOutput("oneshot fire", {31'b0, has_int}, 32'h1);
    readCheck("oneshot wrap", 14'h042, 32'hffff_ffff);
    writeCsr(14'h044, 32'h1, 32'h1);
    repeat (3) tick();
    checkOutput("oneshot quiet", {31'b0, has_int}, 32'h0);
`else
    writeCsr(14'h041, 32'hffff_ffff, 32'h0000_0007);
    readCheck("no tcfg", 14'h041, 32'h0);
    readCheck("no tval", 14'h042, 32'h0);
    repeat (6) tick();
    readCheck("no is11", 14'h005, 32'h000b_0000);
    checkOutput("no timer int", {31'b0, has_int}, 32'h0);
`endif

    writeCsr(14'h030, 32'hffff_ffff, 32'h5a5a_5a5a);
    @(negedge clk);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    readCheck("rst2 crmd", 14'h000, 32'h0000_0008);
    readCheck("rst2 save0", 14'h030, 32'h0);
    readCheck("rst2 ecfg", 14'h004, 32'h0);
    checkOutput("rst2 ertn_pc", ertn_pc, 32'h0);
    checkOutput("rst2 has_int", {31'b0, has_int}, 32'h0);
`ifdef CSR_TIMER_EN
    readCheck("rst2 tval", 14'h042, 32'hffff_ffff);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
